wb_stage: RTL
=============

# wb_stage

Writeback stage of the MINAv2 pipeline, directly downstream of the memory stage. It holds the MEM/WB latch, completes loads by waiting for data-memory read data, commits results to the architectural register file, and provides the decode stage's two combinational read ports with same-cycle write bypass. It also maintains the retired-instruction counter.

## Interface
- `REG_COUNT`, default 32: number of architectural registers. Register 0 is hardwired to zero.
- `AW`, default `$clog2(REG_COUNT)`: register address width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `wb_params` in `wb_params_t`: `rd_addr`, `rd_data`, `mem_op` from the memory stage.
- `in_valid` in 1: `wb_params` carries a live op.
- `busy` out 1: latch is occupied by a load still waiting for data; upstream must hold.
- `load_data` in 32: data-memory read data.
- `load_valid` in 1: `load_data` valid this cycle.
- `rs1_addr`, `rs2_addr` in AW: decode read addresses.
- `rs1_data`, `rs2_data` out 32: read data, combinational.
- `retire` out 1: an op commits this cycle.
- `retire_count` out 32: number of committed ops.

## Operation
- Latch: `valid_q` and `params_q`.
- States:
  - EMPTY: `valid_q`=0.
  - COMMIT: `valid_q`=1 and `mem_op`≠`MEM_OP_LOAD`, or a load with `load_valid`=1.
  - WAIT_LOAD: `valid_q`=1, `mem_op`=`MEM_OP_LOAD`, `load_valid`=0.
- `busy` = WAIT_LOAD, combinational.
- Accept: the latch loads `wb_params` when `in_valid && !busy`. Accept and commit can happen in the same cycle, giving one op per cycle with no bubble.
- Commit, in COMMIT state:
  - `retire`=1 and `retire_count` increments.
  - Write data is `load_data` for a load and `params_q.rd_data` otherwise.
  - The write is suppressed for `MEM_OP_STORE` and when `rd_addr`=0. The op still retires in both cases.
  - If nothing is accepted that cycle, `valid_q` clears.
- WAIT_LOAD holds the latch unchanged and does not retire. It exits on the first cycle with `load_valid`=1, which commits that same cycle.
- `load_valid` while the stage is in EMPTY or holding a non-load is ignored.
- Read ports: return 0 for address 0. If the address equals the address of a write occurring this cycle, return the write data (bypass). Otherwise return the array contents.
- `retire_count` wraps from 0xFFFFFFFF to 0.

## Timing
- Reset clears `valid_q`, `params_q`, all registers and `retire_count` to 0. After reset: `busy`=0, `retire`=0, `rs*_data`=0.
- Reset during WAIT_LOAD drops the pending load. A `load_valid` in the cycle after reset is ignored.
- Latency, non-load: accepted at edge N; `retire`=1 and bypass data visible during cycle N..N+1; array updated at edge N+1.
- Latency, load: commits in the first cycle with `load_valid`=1 at or after cycle N..N+1. `busy` is high in every cycle before that.
- `in_valid` while `busy`=1: not accepted. Upstream must hold `wb_params` stable until `busy` falls.

## Structure
- Shared `types` package: `wb_params_t`, `u32_t`, `mem_op_t` with `MEM_OP_LOAD` and `MEM_OP_STORE`. Add `REG_COUNT` there as the single source for the register count.
- One sub-module, `reg_file`:
  - `REG_COUNT`×32 array with synchronous reset.
  - One write port (`we`, `waddr`, `wdata`).
  - Two combinational read ports with bypass and zero-register handling.
- `wb_stage` keeps the latch, the state logic and the counter.

## Test plan
- Reset, then back-to-back non-load ops r1←0x11, r2←0x22, r3←0x33 on consecutive cycles:
  - `retire` is high for 3 consecutive cycles and `retire_count`=3.
  - Reads return 0x11, 0x22, 0x33.
  - Each value is visible through bypass in its commit cycle.
- Load to r5, `load_data`=0xDEADBEEF with `load_valid` arriving 3 cycles late:
  - `busy` is high for exactly 3 cycles.
  - r5=0xDEADBEEF.
  - The next op, held at the input, is accepted the cycle `busy` falls.
- Store with `rd_addr`=7 and `rd_data`=0xFFFF; write to r0 with 0x1234:
  - r7 stays 0 and r0 reads 0.
  - `retire_count` still increments by 2.
- Spurious `load_valid` while empty: no register changes and `retire` stays 0.
- Reset asserted during WAIT_LOAD, with `load_valid` the following cycle: no write, `busy`=0, `retire_count`=0.
- Preload `retire_count` to 0xFFFFFFFF (via a force or a long run), then commit one op: count wraps to 0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types for the writeback stage: op encoding, MEM/WB latch payload,
// register count and the stage's occupancy states.
package wb_stage_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned AW        = $clog2(REG_COUNT);

  typedef logic [31:0] u32_t;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } mem_op_t;

  typedef struct packed {
    logic [AW-1:0] rd_addr;
    u32_t          rd_data;
    mem_op_t       mem_op;
  } wb_params_t;

  typedef enum logic [1:0] {
    WB_EMPTY,
    WB_COMMIT,
    WB_WAIT_LOAD
  } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle between the writeback stage and its neighbours: MEM/WB handshake,
// data-memory return, decode read ports and retirement status.
interface wb_stage_if;
  import wb_stage_pkg::*;

  wb_params_t    wb_params;
  logic          in_valid;
  logic          busy;
  u32_t          load_data;
  logic          load_valid;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  u32_t          rs1_data;
  u32_t          rs2_data;
  logic          retire;
  u32_t          retire_count;

  modport master (
    output wb_params, in_valid, load_data, load_valid, rs1_addr, rs2_addr,
    input  busy, rs1_data, rs2_data, retire, retire_count
  );

  modport slave (
    input  wb_params, in_valid, load_data, load_valid, rs1_addr, rs2_addr,
    output busy, rs1_data, rs2_data, retire, retire_count
  );
endinterface

// File: rtl/wb_stage_reg_file.sv
// Architectural register file: one write port, two combinational read ports
// with same-cycle write bypass; register 0 always reads as zero.
module reg_file #(
  parameter int unsigned REG_COUNT = wb_stage_pkg::REG_COUNT,
  parameter int unsigned AW        = $clog2(REG_COUNT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr1_i,
  input  logic [AW-1:0] raddr2_i,
  output logic [31:0]   rdata1_o,
  output logic [31:0]   rdata2_o
);

  logic [31:0] regs_q [REG_COUNT];

  // Array update; writes to register 0 are dropped so it stays zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: zero register first, then bypass of this cycle's write, then array.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (raddr1_i == '0)                      rdata1_o = '0;
    else if (we_i && (waddr_i == raddr1_i))  rdata1_o = wdata_i;
    if (raddr2_i == '0)                      rdata2_o = '0;
    else if (we_i && (waddr_i == raddr2_i))  rdata2_o = wdata_i;
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB latch, load completion, register-file commit and
// retired-instruction counter.
module wb_stage #(
  parameter int unsigned REG_COUNT = wb_stage_pkg::REG_COUNT,
  parameter int unsigned AW        = $clog2(REG_COUNT)
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);
  import wb_stage_pkg::*;

  wb_state_e  state;
  logic       valid_q, valid_d;
  wb_params_t params_q, params_d;
  u32_t       retire_count_q;
  logic       commit;
  logic       accept;
  logic       rf_we;
  u32_t       rf_wdata;

  // Occupancy state is derived from the latch and this cycle's load return.
  always_comb begin
    state = WB_EMPTY;
    if (valid_q) begin
      if ((params_q.mem_op == MEM_OP_LOAD) && !bus.load_valid) state = WB_WAIT_LOAD;
      else                                                     state = WB_COMMIT;
    end
  end

  // Next latch contents, handshake outputs and register-file write request.
  always_comb begin
    commit       = (state == WB_COMMIT);
    bus.busy     = (state == WB_WAIT_LOAD);
    bus.retire   = commit;
    accept       = bus.in_valid && (state != WB_WAIT_LOAD);
    valid_d      = valid_q;
    params_d     = params_q;
    if (accept) begin
      valid_d  = 1'b1;
      params_d = bus.wb_params;
    end else if (commit) begin
      valid_d  = 1'b0;
    end
    rf_we    = commit && (params_q.mem_op != MEM_OP_STORE) && (params_q.rd_addr != '0);
    rf_wdata = (params_q.mem_op == MEM_OP_LOAD) ? bus.load_data : params_q.rd_data;
  end

  // Latch and retirement counter; the counter wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= 1'b0;
      params_q       <= '0;
      retire_count_q <= '0;
    end else begin
      valid_q  <= valid_d;
      params_q <= params_d;
      if (commit) retire_count_q <= retire_count_q + 32'd1;
    end
  end

  assign bus.retire_count = retire_count_q;

  reg_file #(
    .REG_COUNT (REG_COUNT),
    .AW        (AW)
  ) u_reg_file (
    .clk_i    (clk),
    .rst_i    (rst),
    .we_i     (rf_we),
    .waddr_i  (params_q.rd_addr),
    .wdata_i  (rf_wdata),
    .raddr1_i (bus.rs1_addr),
    .raddr2_i (bus.rs2_addr),
    .rdata1_o (bus.rs1_data),
    .rdata2_o (bus.rs2_data)
  );

endmodule
